// File: rtl/lotr_pkg.sv
// Shared ring transaction types for the ring stop.
package lotr_pkg;

  typedef enum logic [1:0] {
    RD       = 2'd0,
    RD_RSP   = 2'd1,
    WR       = 2'd2,
    WR_BCAST = 2'd3
  } t_opcode;

endpackage

// File: rtl/ring_stop_tx.sv
// Ring stop transmit/arbitration: registers ring traffic, sinks transactions
// addressed to this core, forwards the rest, and fills free slots from a
// local request FIFO while bounding the number of outstanding local reads.
module ring_stop_tx
  import lotr_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              QClk,
  input  logic              RstQnnnL,
  input  logic [7:0]        CoreID,
  input  logic              RingInputValidQ500H,
  input  t_opcode           RingInputOpcodeQ500H,
  input  logic [31:0]       RingInputAddressQ500H,
  input  logic [31:0]       RingInputDataQ500H,
  input  logic              LocalReqValid,
  input  t_opcode           LocalReqOpcode,
  input  logic [31:0]       LocalReqAddress,
  input  logic [31:0]       LocalReqData,
  output logic              LocalReqReady,
  output logic              LocalRxValidQ501H,
  output t_opcode           LocalRxOpcodeQ501H,
  output logic [31:0]       LocalRxAddressQ501H,
  output logic [31:0]       LocalRxDataQ501H,
  output logic              RingOutputValidQ502H,
  output t_opcode           RingOutputOpcodeQ502H,
  output logic [31:0]       RingOutputAddressQ502H,
  output logic [31:0]       RingOutputDataQ502H,
  output logic [CNT_W-1:0]  OutstandingRdCnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

  // Q501H stage register
  logic        ring_vld_p1;
  t_opcode     ring_op_p1;
  logic [31:0] ring_addr_p1;
  logic [31:0] ring_data_p1;

  // Local request FIFO
  t_opcode          fifo_op   [FIFO_DEPTH];
  logic [31:0]      fifo_addr [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_cnt;

  logic    id_match;
  logic    hit;
  logic    fwd;
  logic    fifo_empty;
  t_opcode head_op;
  logic    issuable;
  logic    push;
  logic    pop;
  logic    rd_inc;
  logic    rsp_dec;

  // Q500H -> Q501H: capture ring slot every cycle
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      ring_vld_p1  <= 1'b0;
      ring_op_p1   <= RD;
      ring_addr_p1 <= '0;
      ring_data_p1 <= '0;
    end else begin
      ring_vld_p1  <= RingInputValidQ500H;
      ring_op_p1   <= RingInputOpcodeQ500H;
      ring_addr_p1 <= RingInputAddressQ500H;
      ring_data_p1 <= RingInputDataQ500H;
    end
  end

  // Q501H: local delivery decode and slot arbitration
  always_comb begin
    id_match   = (ring_addr_p1[31:24] == CoreID);
    hit        = ring_vld_p1 && id_match && (ring_op_p1 != WR_BCAST);
    fwd        = ring_vld_p1 && !hit;
    fifo_empty = (fifo_cnt == '0);
    head_op    = fifo_op[rd_ptr];
    // A blocked RD at the head stalls everything behind it.
    issuable   = (head_op != RD) || (OutstandingRdCnt < MAX_CNT);
    push       = LocalReqValid && LocalReqReady;
    pop        = !fwd && !fifo_empty && issuable;
    rd_inc     = pop && (head_op == RD);
    rsp_dec    = hit && (ring_op_p1 == RD_RSP);
  end

  assign LocalReqReady       = (fifo_cnt != DEPTH_CNT);
  assign LocalRxValidQ501H   = ring_vld_p1 && id_match;
  assign LocalRxOpcodeQ501H  = ring_op_p1;
  assign LocalRxAddressQ501H = ring_addr_p1;
  assign LocalRxDataQ501H    = ring_data_p1;

  // FIFO payload storage; only written on an accepted push
  always_ff @(posedge QClk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= LocalReqOpcode;
      fifo_addr[wr_ptr] <= LocalReqAddress;
      fifo_data[wr_ptr] <= LocalReqData;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
    end
  end

  // Outstanding local read tracking, saturating at zero
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      OutstandingRdCnt <= '0;
    end else if (rd_inc && !rsp_dec) begin
      OutstandingRdCnt <= OutstandingRdCnt + CNT_W'(1);
    end else if (rsp_dec && !rd_inc && (OutstandingRdCnt != '0)) begin
      OutstandingRdCnt <= OutstandingRdCnt - CNT_W'(1);
    end
  end

  // Q501H -> Q502H: ring traffic first, otherwise an issuable FIFO head
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      RingOutputValidQ502H   <= 1'b0;
      RingOutputOpcodeQ502H  <= RD;
      RingOutputAddressQ502H <= '0;
      RingOutputDataQ502H    <= '0;
    end else if (fwd) begin
      RingOutputValidQ502H   <= 1'b1;
      RingOutputOpcodeQ502H  <= ring_op_p1;
      RingOutputAddressQ502H <= ring_addr_p1;
      RingOutputDataQ502H    <= ring_data_p1;
    end else if (pop) begin
      RingOutputValidQ502H   <= 1'b1;
      RingOutputOpcodeQ502H  <= head_op;
      RingOutputAddressQ502H <= fifo_addr[rd_ptr];
      RingOutputDataQ502H    <= fifo_data[rd_ptr];
    end else begin
      RingOutputValidQ502H   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_stop_tx.sv
// Bench for ring_stop_tx: directed scenarios plus a randomized run checked
// against a queue-based transaction model.
module tb_ring_stop_tx;
  import lotr_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam int CW    = $clog2(MAXO + 1);
  localparam logic [7:0] CORE = 8'h01;

  typedef struct packed {
    logic        v;
    t_opcode     op;
    logic [31:0] addr;
    logic [31:0] data;
  } item_t;

  logic          QClk = 1'b0;
  logic          RstQnnnL;
  logic [7:0]    CoreID;
  logic          RingInputValidQ500H;
  t_opcode       RingInputOpcodeQ500H;
  logic [31:0]   RingInputAddressQ500H;
  logic [31:0]   RingInputDataQ500H;
  logic          LocalReqValid;
  t_opcode       LocalReqOpcode;
  logic [31:0]   LocalReqAddress;
  logic [31:0]   LocalReqData;
  logic          LocalReqReady;
  logic          LocalRxValidQ501H;
  t_opcode       LocalRxOpcodeQ501H;
  logic [31:0]   LocalRxAddressQ501H;
  logic [31:0]   LocalRxDataQ501H;
  logic          RingOutputValidQ502H;
  t_opcode       RingOutputOpcodeQ502H;
  logic [31:0]   RingOutputAddressQ502H;
  logic [31:0]   RingOutputDataQ502H;
  logic [CW-1:0] OutstandingRdCnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  item_t m_q501;
  item_t m_out;
  item_t m_fifo[$];
  int    m_cnt;

  ring_stop_tx #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .QClk(QClk), .RstQnnnL(RstQnnnL), .CoreID(CoreID),
    .RingInputValidQ500H(RingInputValidQ500H), .RingInputOpcodeQ500H(RingInputOpcodeQ500H),
    .RingInputAddressQ500H(RingInputAddressQ500H), .RingInputDataQ500H(RingInputDataQ500H),
    .LocalReqValid(LocalReqValid), .LocalReqOpcode(LocalReqOpcode),
    .LocalReqAddress(LocalReqAddress), .LocalReqData(LocalReqData),
    .LocalReqReady(LocalReqReady),
    .LocalRxValidQ501H(LocalRxValidQ501H), .LocalRxOpcodeQ501H(LocalRxOpcodeQ501H),
    .LocalRxAddressQ501H(LocalRxAddressQ501H), .LocalRxDataQ501H(LocalRxDataQ501H),
    .RingOutputValidQ502H(RingOutputValidQ502H), .RingOutputOpcodeQ502H(RingOutputOpcodeQ502H),
    .RingOutputAddressQ502H(RingOutputAddressQ502H), .RingOutputDataQ502H(RingOutputDataQ502H),
    .OutstandingRdCnt(OutstandingRdCnt)
  );

  always #5 QClk = ~QClk;

  task automatic m_reset();
    m_q501 = '0;
    m_out  = '0;
    m_fifo.delete();
    m_cnt  = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    item_t nout;
    item_t head;
    bit    hit;
    bit    rdy;
    hit  = m_q501.v && (m_q501.addr[31:24] == CORE) && (m_q501.op != WR_BCAST);
    rdy  = (m_fifo.size() < DEPTH);
    nout = m_out;
    nout.v = 1'b0;
    if (m_q501.v && !hit) begin
      nout = m_q501;
    end else if (m_fifo.size() > 0 && (m_fifo[0].op != RD || m_cnt < MAXO)) begin
      head = m_fifo.pop_front();
      nout = head;
      nout.v = 1'b1;
      if (head.op == RD) m_cnt++;
    end
    if (hit && m_q501.op == RD_RSP && m_cnt > 0) m_cnt--;
    if (LocalReqValid && rdy)
      m_fifo.push_back({1'b1, LocalReqOpcode, LocalReqAddress, LocalReqData});
    m_q501 = {RingInputValidQ500H, RingInputOpcodeQ500H, RingInputAddressQ500H, RingInputDataQ500H};
    m_out  = nout;
  endtask

  task automatic tick();
    model_step();
    @(posedge QClk);
    #1;
  endtask

  task automatic ring_idle();
    RingInputValidQ500H   = 1'b0;
    RingInputOpcodeQ500H  = RD;
    RingInputAddressQ500H = '0;
    RingInputDataQ500H    = '0;
  endtask

  task automatic ring_drive(input t_opcode op, input logic [31:0] addr, input logic [31:0] data);
    RingInputValidQ500H   = 1'b1;
    RingInputOpcodeQ500H  = op;
    RingInputAddressQ500H = addr;
    RingInputDataQ500H    = data;
  endtask

  task automatic local_drive(input logic v, input t_opcode op, input logic [31:0] addr, input logic [31:0] data);
    LocalReqValid   = v;
    LocalReqOpcode  = op;
    LocalReqAddress = addr;
    LocalReqData    = data;
  endtask

  task automatic test_reset();
    RstQnnnL = 1'b0;
    ring_idle();
    local_drive(1'b0, RD, '0, '0);
    m_reset();
    repeat (2) @(posedge QClk);
    #2;
    total++;
    if (RingOutputValidQ502H !== 1'b0 || LocalRxValidQ501H !== 1'b0 ||
        OutstandingRdCnt !== '0 || RingOutputAddressQ502H !== '0 ||
        RingOutputDataQ502H !== '0 || RingOutputOpcodeQ502H !== RD) begin
      bad++;
      $display("FAIL reset_state: outv=%0b rxv=%0b cnt=%0d addr=%h data=%h op=%0d, required all 0",
               RingOutputValidQ502H, LocalRxValidQ501H, OutstandingRdCnt,
               RingOutputAddressQ502H, RingOutputDataQ502H, RingOutputOpcodeQ502H);
    end
    RstQnnnL = 1'b1;
    #1;
    total++;
    if (LocalReqReady !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %0b required 1", LocalReqReady);
    end
    tick();
  endtask

  task automatic test_passthrough();
    ring_drive(WR, 32'h0200_0001, 32'h0200_0001);
    tick();
    ring_idle();
    total++;
    if (LocalRxValidQ501H !== 1'b0 || RingOutputValidQ502H !== 1'b0) begin
      bad++;
      $display("FAIL pass_n1: rxv=%0b outv=%0b required 0 0", LocalRxValidQ501H, RingOutputValidQ502H);
    end
    tick();
    total++;
    if (RingOutputValidQ502H !== 1'b1 || RingOutputOpcodeQ502H !== WR ||
        RingOutputAddressQ502H !== 32'h0200_0001 || RingOutputDataQ502H !== 32'h0200_0001 ||
        LocalRxValidQ501H !== 1'b0) begin
      bad++;
      $display("FAIL pass_n2: v=%0b op=%0d addr=%h data=%h rxv=%0b required 1 WR 02000001 02000001 0",
               RingOutputValidQ502H, RingOutputOpcodeQ502H, RingOutputAddressQ502H,
               RingOutputDataQ502H, LocalRxValidQ501H);
    end
    tick();
    total++;
    if (RingOutputValidQ502H !== 1'b0) begin
      bad++;
      $display("FAIL pass_n3: outv=%0b required 0", RingOutputValidQ502H);
    end
  endtask

  task automatic test_hit();
    ring_drive(WR, 32'h0100_0010, 32'hDEAD_BEEF);
    tick();
    ring_idle();
    total++;
    if (LocalRxValidQ501H !== 1'b1 || LocalRxOpcodeQ501H !== WR ||
        LocalRxAddressQ501H !== 32'h0100_0010 || LocalRxDataQ501H !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL hit_rx: v=%0b op=%0d addr=%h data=%h required 1 WR 01000010 deadbeef",
               LocalRxValidQ501H, LocalRxOpcodeQ501H, LocalRxAddressQ501H, LocalRxDataQ501H);
    end
    tick();
    total++;
    if (RingOutputValidQ502H !== 1'b0) begin
      bad++;
      $display("FAIL hit_not_fwd: outv=%0b required 0", RingOutputValidQ502H);
    end
  endtask

  task automatic test_local_insert();
    logic [31:0] d;
    d = $urandom;
    local_drive(1'b1, WR, 32'h0300_0004, d);
    tick();
    local_drive(1'b0, RD, '0, '0);
    total++;
    if (LocalReqReady !== 1'b1 || RingOutputValidQ502H !== 1'b0) begin
      bad++;
      $display("FAIL insert_n1: ready=%0b outv=%0b required 1 0", LocalReqReady, RingOutputValidQ502H);
    end
    tick();
    total++;
    if (RingOutputValidQ502H !== 1'b1 || RingOutputOpcodeQ502H !== WR ||
        RingOutputAddressQ502H !== 32'h0300_0004 || RingOutputDataQ502H !== d ||
        LocalReqReady !== 1'b1) begin
      bad++;
      $display("FAIL insert_n2: v=%0b op=%0d addr=%h data=%h ready=%0b required 1 WR 03000004 %h 1",
               RingOutputValidQ502H, RingOutputOpcodeQ502H, RingOutputAddressQ502H,
               RingOutputDataQ502H, LocalReqReady, d);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen_addr[$];
    int          seen_cyc[$];
    logic [31:0] want;
    int          idx;
    bit          acc;
    bit          order_ok;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) ring_drive(WR, {8'h02, 24'(c)}, $urandom);
      else ring_idle();
      local_drive(idx < 5, WR, 32'h0300_0100 + 32'(idx), $urandom);
      acc = LocalReqValid && LocalReqReady;
      tick();
      if (acc) idx++;
      if (RingOutputValidQ502H === 1'b1) begin
        seen_addr.push_back(RingOutputAddressQ502H);
        seen_cyc.push_back(c);
      end
      if (c == 7) begin
        total++;
        if (idx !== 4 || LocalReqReady !== 1'b0) begin
          bad++;
          $display("FAIL b2b_full: accepted=%0d ready=%0b required 4 0", idx, LocalReqReady);
        end
      end
    end
    local_drive(1'b0, RD, '0, '0);
    total++;
    if (idx !== 5) begin
      bad++;
      $display("FAIL b2b_accepted: got %0d required 5", idx);
    end
    order_ok = (seen_addr.size() == 13);
    for (int j = 0; j < seen_addr.size() && order_ok; j++) begin
      want = (j < 8) ? {8'h02, 24'(j)} : 32'h0300_0100 + 32'(j - 8);
      if (seen_addr[j] !== want || seen_cyc[j] !== seen_cyc[0] + j) order_ok = 1'b0;
    end
    total++;
    if (!order_ok) begin
      bad++;
      $display("FAIL b2b_order: outputs=%0d first=%h last=%h required 13 contiguous, traffic then locals in push order",
               seen_addr.size(), (seen_addr.size() > 0) ? seen_addr[0] : 32'h0,
               (seen_addr.size() > 0) ? seen_addr[seen_addr.size()-1] : 32'h0);
    end
  endtask

  task automatic test_rd_limit();
    int issued;
    issued = 0;
    for (int c = 0; c < 7; c++) begin
      local_drive(c < 3, RD, 32'h0400_0000, 32'(c));
      tick();
      if (RingOutputValidQ502H === 1'b1 && RingOutputOpcodeQ502H === RD) issued++;
    end
    local_drive(1'b0, RD, '0, '0);
    total++;
    if (issued !== 2 || OutstandingRdCnt !== CW'(2)) begin
      bad++;
      $display("FAIL rd_limit: issued=%0d cnt=%0d required 2 2", issued, OutstandingRdCnt);
    end
    ring_drive(RD_RSP, 32'h0100_0000, $urandom);
    tick();
    ring_idle();
    total++;
    if (OutstandingRdCnt !== CW'(2) || LocalRxValidQ501H !== 1'b1 || LocalRxOpcodeQ501H !== RD_RSP) begin
      bad++;
      $display("FAIL rsp_n1: cnt=%0d rxv=%0b rxop=%0d required 2 1 RD_RSP",
               OutstandingRdCnt, LocalRxValidQ501H, LocalRxOpcodeQ501H);
    end
    tick();
    total++;
    if (OutstandingRdCnt !== CW'(1) || RingOutputValidQ502H !== 1'b0) begin
      bad++;
      $display("FAIL rsp_n2: cnt=%0d outv=%0b required 1 0", OutstandingRdCnt, RingOutputValidQ502H);
    end
    tick();
    total++;
    if (RingOutputValidQ502H !== 1'b1 || RingOutputOpcodeQ502H !== RD ||
        RingOutputAddressQ502H !== 32'h0400_0000 || OutstandingRdCnt !== CW'(2)) begin
      bad++;
      $display("FAIL rsp_n3: v=%0b op=%0d addr=%h cnt=%0d required 1 RD 04000000 2",
               RingOutputValidQ502H, RingOutputOpcodeQ502H, RingOutputAddressQ502H, OutstandingRdCnt);
    end
  endtask

  task automatic test_reset_mid();
    int leaks;
    for (int c = 0; c < 3; c++) begin
      local_drive(1'b1, RD, 32'h0400_0100 + 32'(c), '0);
      tick();
    end
    local_drive(1'b0, RD, '0, '0);
    tick();
    #2;
    RstQnnnL = 1'b0;
    m_reset();
    #1;
    total++;
    if (RingOutputValidQ502H !== 1'b0 || LocalRxValidQ501H !== 1'b0 ||
        OutstandingRdCnt !== '0 || RingOutputAddressQ502H !== '0 ||
        RingOutputDataQ502H !== '0 || RingOutputOpcodeQ502H !== RD ||
        LocalRxAddressQ501H !== '0 || LocalRxDataQ501H !== '0) begin
      bad++;
      $display("FAIL reset_mid: outv=%0b rxv=%0b cnt=%0d addr=%h required all 0",
               RingOutputValidQ502H, LocalRxValidQ501H, OutstandingRdCnt, RingOutputAddressQ502H);
    end
    @(posedge QClk);
    #3;
    RstQnnnL = 1'b1;
    #1;
    total++;
    if (LocalReqReady !== 1'b1 || OutstandingRdCnt !== '0) begin
      bad++;
      $display("FAIL reset_release: ready=%0b cnt=%0d required 1 0", LocalReqReady, OutstandingRdCnt);
    end
    leaks = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (RingOutputValidQ502H !== 1'b0) leaks++;
    end
    total++;
    if (leaks !== 0) begin
      bad++;
      $display("FAIL reset_stale: valid cycles=%0d required 0", leaks);
    end
  endtask

  task automatic test_random();
    logic [7:0] ids[3];
    bit         exp_rx;
    ids[0] = 8'h01; ids[1] = 8'h02; ids[2] = 8'h05;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1)
        ring_drive(t_opcode'($urandom_range(0, 3)),
                   {ids[$urandom_range(0, 2)], 24'($urandom)}, $urandom);
      else
        ring_idle();
      local_drive(1'($urandom_range(0, 1)), t_opcode'($urandom_range(0, 3)),
                  {8'h06, 24'($urandom)}, $urandom);
      tick();
      exp_rx = m_q501.v && (m_q501.addr[31:24] == CORE);
      total++;
      if (LocalReqReady !== (m_fifo.size() < DEPTH)) begin
        bad++;
        $display("FAIL rnd_ready c=%0d: got %0b required %0b", c, LocalReqReady, m_fifo.size() < DEPTH);
      end
      total++;
      if (LocalRxValidQ501H !== exp_rx ||
          (exp_rx && (LocalRxOpcodeQ501H !== m_q501.op || LocalRxAddressQ501H !== m_q501.addr ||
                      LocalRxDataQ501H !== m_q501.data))) begin
        bad++;
        $display("FAIL rnd_rx c=%0d: v=%0b op=%0d addr=%h required %0b %0d %h",
                 c, LocalRxValidQ501H, LocalRxOpcodeQ501H, LocalRxAddressQ501H,
                 exp_rx, m_q501.op, m_q501.addr);
      end
      total++;
      if (RingOutputValidQ502H !== m_out.v ||
          (m_out.v && (RingOutputOpcodeQ502H !== m_out.op || RingOutputAddressQ502H !== m_out.addr ||
                       RingOutputDataQ502H !== m_out.data))) begin
        bad++;
        $display("FAIL rnd_out c=%0d: v=%0b op=%0d addr=%h data=%h required %0b %0d %h %h",
                 c, RingOutputValidQ502H, RingOutputOpcodeQ502H, RingOutputAddressQ502H,
                 RingOutputDataQ502H, m_out.v, m_out.op, m_out.addr, m_out.data);
      end
      total++;
      if (OutstandingRdCnt !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL rnd_cnt c=%0d: got %0d required %0d", c, OutstandingRdCnt, m_cnt);
      end
    end
    ring_idle();
    local_drive(1'b0, RD, '0, '0);
  endtask

  initial begin
    CoreID = CORE;
    test_reset();
    test_passthrough();
    test_hit();
    test_local_insert();
    test_back_to_back();
    test_rd_limit();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
